mem_access_unit: RTL
====================

# mem_access_unit

Load/store initiator between the CPU's MEM stage and the word-wide data memory. It accepts one load or store request at a time and issues word-aligned read and write cycles on the memory port. Sub-word stores (sb/sh) run as read-modify-write, because the memory writes only whole words. Loads return a sign- or zero-extended result, and misaligned or out-of-range accesses raise an exception without touching memory.

## Interface
- (no parameters; memory window is fixed at 0x0000_0000–0x0000_0FFF, 1024 words)
- clk  in  1  clock; all state changes on posedge
- reset  in  1  synchronous, active-high
- req  in  1  request; sampled only while ready=1
- op  in  3  000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu, 101 sw, 110 sb, 111 sh
- addr  in  32  byte address
- wdata  in  32  store data; sb uses [7:0], sh uses [15:0]
- pc  in  32  PC of the requesting instruction, forwarded for the memory write log
- ready  out  1  1 when state=IDLE
- done  out  1  one-cycle completion pulse
- rdata  out  32  load result, valid while done=1, otherwise 0
- adel  out  1  load address exception, valid with done
- ades  out  1  store address exception, valid with done
- mem_re  out  1  memory read enable; read data is combinational in the same cycle
- mem_we  out  1  memory write enable; the write commits at the next posedge
- mem_addr  out  32  {addr[31:2],2'b00} during access states, else 0
- mem_wd  out  32  write word during WRITE, else 0
- mem_pc  out  32  latched pc
- mem_rd  in  32  memory read data

## Operation
- States:
  - IDLE
  - READ: load, or first half of RMW
  - WRITE
  - RESP
- Acceptance: at a posedge with state=IDLE and req=1, latch op/addr/wdata/pc; req in any other state is ignored (not queued).
- Exception check at acceptance, with RESP as the next state:
  - addr[31:12]≠0: exception
  - lw/sw with addr[1:0]≠0: exception
  - lh/lhu/sh with addr[0]≠0: exception
  - Load ops set adel; store ops set ades.
  - No memory cycle is issued.
- Transitions:
  - IDLE→READ for loads, sb, sh
  - IDLE→WRITE for sw
  - READ→RESP for loads; rdata is registered from mem_rd at the READ→RESP edge
  - READ→WRITE for sb/sh; mem_rd is captured into a merge register
  - WRITE→RESP
  - RESP→IDLE unconditionally
- Byte lanes, little-endian:
  - Byte k=addr[1:0] occupies [8k+7:8k].
  - Halfword h=addr[1] occupies [16h+15:16h].
- Load extension:
  - lb/lh sign-extend from bit 7/15.
  - lbu/lhu zero-extend.
  - lw passes the word through.
- Store merge:
  - sb replaces only byte k of the captured word with wdata[7:0].
  - sh replaces only halfword h with wdata[15:0].
  - sw writes wdata unmodified.
- Access-state outputs:
  - mem_re=1 only in READ.
  - mem_we=(state==WRITE)&&!reset.
  - Each access produces exactly one write cycle at most.
- Status outputs:
  - done=1 only in RESP.
  - adel/ades/rdata are nonzero only in RESP.

## Timing
- Reset: state=IDLE, all latches cleared.
  - ready=1; done, adel, ades, mem_re, mem_we = 0.
  - rdata, mem_addr, mem_wd, mem_pc = 0.
- Latency from the acceptance edge to the done cycle:
  - loads and sw: 2 cycles
  - sb/sh: 3 cycles
  - exception: 1 cycle
- Back-to-back: the next request is accepted at the edge ending the IDLE cycle after RESP. Peak throughput is one lw per 3 cycles.
- Reset mid-operation, in any state:
  - The next state is IDLE.
  - mem_we is forced to 0 in the reset cycle, so a pending RMW write is abandoned and memory is unchanged by this block.
  - No done pulse is produced for the aborted request.
- Simultaneous reset and req: reset wins and the request is dropped.
- Inputs may change freely after acceptance; only latched values are used.

## Test plan
- Reset, then sw wdata=0x12345678 addr=0x10:
  - one mem_we cycle with mem_addr=0x10, mem_wd=0x12345678
  - done 2 cycles after acceptance
  - a following lw 0x10 returns rdata=0x12345678
- sb wdata=0x000000AB addr=0x11 over word 0x12345678:
  - READ then WRITE, mem_wd=0x1234AB78, done at +3
  - lb 0x11 returns 0xFFFFFFAB
  - lbu 0x11 returns 0x000000AB
- sh wdata=0x00008001 addr=0x12 over 0x1234AB78:
  - mem_wd=0x8001AB78
  - lh 0x12 returns 0xFFFF8001
  - lhu 0x12 returns 0x00008001
  - lh 0x10 returns 0xFFFFAB78
- Exceptions, each with mem_re=mem_we=0 throughout:
  - lw 0x13: done at +1 with adel=1, rdata=0
  - sh 0x11: ades=1
  - sw 0x00001000: ades=1
  - lb 0x00002003: adel=1
- Reset asserted while in READ of sb 0x11:
  - next cycle ready=1, done never pulses, mem_we stays 0
  - lw 0x10 still returns the prior word
- req held high with a new addr each cycle:
  - only the addr present at each IDLE edge is accepted
  - accesses complete in order with one done per accepted request

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store initiator between the MEM stage and a word-wide data memory.
// Sub-word stores are done as read-modify-write; bad addresses raise adel/ades without a memory cycle.
module mem_access_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic        ready,
    output logic        done,
    output logic [31:0] rdata,
    output logic        adel,
    output logic        ades,
    output logic        mem_re,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic [31:0] mem_pc,
    input  logic [31:0] mem_rd
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
    typedef enum logic [2:0] {
        OP_LW = 3'b000, OP_LB = 3'b001, OP_LBU = 3'b010, OP_LH = 3'b011,
        OP_LHU = 3'b100, OP_SW = 3'b101, OP_SB = 3'b110, OP_SH = 3'b111
    } op_t;

    state_t      state, next_state;
    op_t         op_in, op_q;
    logic [31:0] addr_q, wdata_q, pc_q, merge_q, rdata_q;
    logic        adel_q, ades_q;
    logic        in_store, misaligned, exc, q_store;
    logic [1:0]  lane;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_val, store_word;

    assign op_in = op_t'(op);

    // Address check on the incoming request, evaluated at the acceptance edge
    always_comb begin
        in_store   = op_in inside {OP_SW, OP_SB, OP_SH};
        misaligned = 1'b0;
        case (op_in)
            OP_LW, OP_SW:         misaligned = (addr[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH: misaligned = addr[0];
            default:              misaligned = 1'b0;
        endcase
        exc = (addr[31:12] != '0) || misaligned;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (req) begin
                    if (exc)                next_state = RESP;
                    else if (op_in == OP_SW) next_state = WRITE;
                    else                    next_state = READ;
                end
            end
            READ:    next_state = (op_q == OP_SB || op_q == OP_SH) ? WRITE : RESP;
            WRITE:   next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Lane extraction and merge, both driven by the latched request
    always_comb begin
        lane     = addr_q[1:0];
        q_store  = op_q inside {OP_SW, OP_SB, OP_SH};
        byte_v   = mem_rd[{lane, 3'b000} +: 8];
        half_v   = mem_rd[{addr_q[1], 4'b0000} +: 16];
        load_val = mem_rd;
        case (op_q)
            OP_LB:   load_val = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  load_val = {24'd0, byte_v};
            OP_LH:   load_val = {{16{half_v[15]}}, half_v};
            OP_LHU:  load_val = {16'd0, half_v};
            default: load_val = mem_rd;
        endcase
        store_word = merge_q;
        case (op_q)
            OP_SB:   store_word[{lane, 3'b000} +: 8]      = wdata_q[7:0];
            OP_SH:   store_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: store_word = wdata_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q    <= OP_LW;
            addr_q  <= '0;
            wdata_q <= '0;
            pc_q    <= '0;
            merge_q <= '0;
            rdata_q <= '0;
            adel_q  <= 1'b0;
            ades_q  <= 1'b0;
        end else begin
            if (state == IDLE && req) begin
                op_q    <= op_in;
                addr_q  <= addr;
                wdata_q <= wdata;
                pc_q    <= pc;
                rdata_q <= '0;
                adel_q  <= exc && !in_store;
                ades_q  <= exc && in_store;
            end
            if (state == READ) begin
                merge_q <= mem_rd;
                rdata_q <= q_store ? '0 : load_val;
            end
        end
    end

    assign ready    = (state == IDLE);
    assign done     = (state == RESP);
    assign rdata    = done ? rdata_q : '0;
    assign adel     = done && adel_q;
    assign ades     = done && ades_q;
    assign mem_re   = (state == READ);
    assign mem_we   = (state == WRITE) && !reset;
    assign mem_addr = (state == READ || state == WRITE) ? {addr_q[31:2], 2'b00} : '0;
    assign mem_wd   = (state == WRITE) ? store_word : '0;
    assign mem_pc   = pc_q;
endmodule
